// File: rtl/traffic_fsm_if.sv
// Signal bundle between the input synchronizer / testbench (master) and traffic_fsm (slave).
// It carries the synchronized sensor, walk and reprogram inputs, the 1 Hz tick and the lamp/debug outputs.
interface traffic_fsm_if #(
  parameter int unsigned TW = 4
);
  logic          Sensor_Sync;
  logic          WR_Sync;
  logic          Prog_Sync;
  logic [1:0]    Time_Sel;
  logic [TW-1:0] Time_Value;
  logic          One_Hz_En;
  logic [2:0]    Main_Light;
  logic [2:0]    Side_Light;
  logic          Walk_Lamp;
  logic [2:0]    State_Out;

  modport master (
    output Sensor_Sync, WR_Sync, Prog_Sync, Time_Sel, Time_Value, One_Hz_En,
    input  Main_Light, Side_Light, Walk_Lamp, State_Out
  );

  modport slave (
    input  Sensor_Sync, WR_Sync, Prog_Sync, Time_Sel, Time_Value, One_Hz_En,
    output Main_Light, Side_Light, Walk_Lamp, State_Out
  );
endinterface

// File: rtl/traffic_fsm.sv
// Main/side-street traffic-light sequencer with a pedestrian walk phase, tick-driven down-counter
// and three run-time reprogrammable intervals (base, extended, yellow).
//
// state  | meaning
// S_MG   | main green, side red (base interval)
// S_MG2  | main green extension (ext if side car seen at entry, else base)
// S_MY   | main yellow
// S_WALK | all red, walk lamp on (ext interval)
// S_SG   | side green (base interval)
// S_SG2  | side green extension (ext interval)
// S_SY   | side yellow
module traffic_fsm #(
  parameter int unsigned T_BASE = 6,
  parameter int unsigned T_EXT  = 3,
  parameter int unsigned T_YEL  = 2,
  parameter int unsigned TW     = 4
) (
  input logic         clk,
  input logic         Reset_n,
  traffic_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MG2  = 3'd1,
    S_MY   = 3'd2,
    S_WALK = 3'd3,
    S_SG   = 3'd4,
    S_SG2  = 3'd5,
    S_SY   = 3'd6
  } state_t;

  localparam logic [TW-1:0] DEF_B = TW'(T_BASE);
  localparam logic [TW-1:0] DEF_E = TW'(T_EXT);
  localparam logic [TW-1:0] DEF_Y = TW'(T_YEL);
  localparam logic [TW-1:0] ONE   = TW'(1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] base_q, base_d;
  logic [TW-1:0] ext_q, ext_d;
  logic [TW-1:0] yel_q, yel_d;
  logic          walk_q, walk_d;

  logic [2:0]    main_light;
  logic [2:0]    side_light;
  logic          walk_lamp;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q <= S_MG;
      timer_q <= DEF_B - ONE;
      base_q  <= DEF_B;
      ext_q   <= DEF_E;
      yel_q   <= DEF_Y;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      base_q  <= base_d;
      ext_q   <= ext_d;
      yel_q   <= yel_d;
      walk_q  <= walk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    base_d  = base_q;
    ext_d   = ext_q;
    yel_d   = yel_q;
    walk_d  = bus.WR_Sync | walk_q;

    if (bus.Prog_Sync) begin
      // A zero value restores the register's default rather than programming a zero-length phase.
      case (bus.Time_Sel)
        2'd0:    base_d = (bus.Time_Value == '0) ? DEF_B : bus.Time_Value;
        2'd1:    ext_d  = (bus.Time_Value == '0) ? DEF_E : bus.Time_Value;
        2'd2:    yel_d  = (bus.Time_Value == '0) ? DEF_Y : bus.Time_Value;
        default: ;
      endcase
      state_d = S_MG;
      timer_d = base_d - ONE;
      walk_d  = 1'b0;
    end else begin
      case (state_q)
        S_MG, S_MG2, S_MY, S_WALK, S_SG, S_SG2, S_SY: begin
          if (bus.One_Hz_En) begin
            if (timer_q != '0) begin
              timer_d = timer_q - ONE;
            end else begin
              case (state_q)
                S_MG: begin
                  state_d = S_MG2;
                  timer_d = (bus.Sensor_Sync ? ext_q : base_q) - ONE;
                end
                S_MG2: begin
                  state_d = S_MY;
                  timer_d = yel_q - ONE;
                end
                S_MY: begin
                  if (walk_q) begin
                    state_d = S_WALK;
                    timer_d = ext_q - ONE;
                    // Only a request arriving in this entry cycle survives into the next round.
                    walk_d  = bus.WR_Sync;
                  end else begin
                    state_d = S_SG;
                    timer_d = base_q - ONE;
                  end
                end
                S_WALK: begin
                  state_d = S_SG;
                  timer_d = base_q - ONE;
                end
                S_SG: begin
                  if (bus.Sensor_Sync) begin
                    state_d = S_SG2;
                    timer_d = ext_q - ONE;
                  end else begin
                    state_d = S_SY;
                    timer_d = yel_q - ONE;
                  end
                end
                S_SG2: begin
                  state_d = S_SY;
                  timer_d = yel_q - ONE;
                end
                default: begin
                  state_d = S_MG;
                  timer_d = base_q - ONE;
                end
              endcase
            end
          end
        end
        default: begin
          state_d = S_MG;
          timer_d = base_q - ONE;
        end
      endcase
    end
  end

  always_comb begin
    main_light = 3'b100;
    side_light = 3'b100;
    walk_lamp  = 1'b0;
    case (state_q)
      S_MG, S_MG2: main_light = 3'b001;
      S_MY:        main_light = 3'b010;
      S_WALK:      walk_lamp  = 1'b1;
      S_SG, S_SG2: side_light = 3'b001;
      S_SY:        side_light = 3'b010;
      default:     ;
    endcase
  end

  assign bus.Main_Light = main_light;
  assign bus.Side_Light = side_light;
  assign bus.Walk_Lamp  = walk_lamp;
  assign bus.State_Out  = state_q;

endmodule

// File: doc/traffic_fsm.md
Name: traffic_fsm

Overview:
- Main/side-street traffic-light controller with a pedestrian walk phase.
- Sits directly downstream of the input synchronizer and consumes its registered Sensor, Walk_Request and Reprogram signals.
- Advances on a one-cycle 1 Hz enable pulse, using an internal countdown timer.
- Holds three run-time reprogrammable interval registers: base, extended and yellow.

Parameters:
- T_BASE, 6, default base interval in ticks.
- T_EXT, 3, default extended interval in ticks.
- T_YEL, 2, default yellow interval in ticks.
- TW, 4, width of interval registers and countdown timer.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- Reset_n  input  1  synchronous active-low reset.
- Sensor_Sync  input  1  side-street vehicle present (synchronized).
- WR_Sync  input  1  pedestrian walk request (synchronized).
- Prog_Sync  input  1  reprogram strobe (synchronized).
- Time_Sel  input  2  interval select: 0=base, 1=ext, 2=yellow, 3=reserved (ignored).
- Time_Value  input  TW  new interval value in ticks.
- One_Hz_En  input  1  one-cycle tick enable.
- Main_Light  output  3  {R,Y,G} for main street.
- Side_Light  output  3  {R,Y,G} for side street.
- Walk_Lamp  output  1  pedestrian walk indicator.
- State_Out  output  3  current state encoding, for debug.

Behaviour:
- Interface: one clock (clk). Reset is synchronous, active-low (Reset_n), sampled on the rising edge of clk.
- States and encodings:
  - S_MG=0: main G, side R.
  - S_MG2=1: main G, side R.
  - S_MY=2: main Y, side R.
  - S_WALK=3: both R, Walk_Lamp=1.
  - S_SG=4: main R, side G.
  - S_SG2=5: main R, side G.
  - S_SY=6: main R, side Y.
- Outputs are a pure decode of the state register, so they change the cycle after the transition edge. In all states except S_WALK, Walk_Lamp=0.
- Timer:
  - On state entry, the timer loads (duration-1).
  - Each One_Hz_En pulse decrements it.
  - A One_Hz_En pulse while timer==0 causes the transition. Each state therefore lasts exactly its duration in ticks.
  - Without One_Hz_En, the timer and state hold.
- Transitions and durations (B/E/Y = current base/ext/yellow register):
  - S_MG lasts B, then goes to S_MG2.
  - S_MG2 duration is chosen by Sensor_Sync sampled in the S_MG→S_MG2 transition cycle: E if 1, B if 0. Then S_MG2 goes to S_MY.
  - S_MY lasts Y. It then goes to S_WALK if the walk latch is set, else to S_SG.
  - S_WALK lasts E, then goes to S_SG.
  - S_SG lasts B. It goes to S_SG2 if Sensor_Sync=1 in the expiry cycle, else to S_SY.
  - S_SG2 lasts E, then goes to S_SY.
  - S_SY lasts Y, then goes to S_MG.
- Walk latch:
  - next = WR_Sync | (latch & ~entering_S_WALK).
  - A request arriving in the S_WALK entry cycle stays latched and is served on the next round.
- Reprogram: when Prog_Sync=1 in a cycle:
  - If Time_Sel<3, the selected register loads Time_Value. Time_Value=0 loads that register's parameter default instead.
  - The state goes to S_MG and the timer loads (B_new-1), using the post-update base value.
  - The walk latch clears.
  - One_Hz_En is ignored that cycle.
  - If Prog_Sync is held high, the block reprograms and restarts every cycle.
- Priority: Reset_n=0 > Prog_Sync > tick-driven transition.
- Reset values:
  - state S_MG; timer T_BASE-1; walk latch 0.
  - Registers B/E/Y = T_BASE/T_EXT/T_YEL.
  - Main_Light=3'b001, Side_Light=3'b100, Walk_Lamp=0, State_Out=0.
- Reset asserted mid-state aborts immediately: the next edge yields the reset values, with no partial phase completion.
- Unused state encoding 7 recovers to S_MG on the next edge.
- Arithmetic: the timer is unsigned TW bits and never underflows, because a transition occurs at 0.

Test Plan:
- Reset, then 22 ticks with Sensor=0 and WR=0 → S_MG 6, S_MG2 6, S_MY 2, S_SG 6, S_SY 2 ticks; back in S_MG after tick 22. Lights match the decode at every boundary.
- Sensor_Sync=1 held throughout → S_MG2 lasts 3 ticks and S_SG2 (3 ticks) is inserted. Full cycle = 6+3+2+6+3+2 = 22 ticks.
- One-cycle WR_Sync pulse during S_MG → after S_MY, S_WALK for 3 ticks with Walk_Lamp=1 and both lights 3'b100, then S_SG. A second WR pulse in the S_WALK entry cycle is served on the next round.
- Prog_Sync with Time_Sel=2, Time_Value=5 while in S_SG → next cycle S_MG, timer=5 (B-1), latch cleared. The next S_MY lasts 5 ticks. Then Time_Sel=2, Time_Value=0 restores yellow=2.
- Reset_n=0 for one cycle in mid S_SG2 with the latch set → next edge gives S_MG, Main_Light=001, latch=0, and default intervals restored.
- Ticks withheld for 100 cycles → state, timer and outputs are unchanged. One_Hz_En held high continuously → each state lasts its duration in clk cycles.
